// File: rtl/acs_node.sv
// Add-compare-select node for one Viterbi trellis state, with a registered path metric and survivor bit.
// Optional build macro ACS_SAT_EN clamps the post-normalise metric to the largest PM_W-bit value.
module acs_node #(
   parameter int PM_W    = 8,
   parameter int BM_W    = 2,
   parameter int IS_ZERO = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic [PM_W-1:0] pm_a,
   input  logic [PM_W-1:0] pm_b,
   input  logic [BM_W-1:0] bm_a,
   input  logic [BM_W-1:0] bm_b,
   input  logic            norm_in,
   output logic [PM_W-1:0] pm_out,
   output logic            decision,
   output logic            out_valid,
   output logic            pm_msb
);

   // State 0 starts with a zero metric; every other state starts a quarter-range behind it.
   localparam logic [PM_W-1:0] START_PM = (IS_ZERO != 0) ? {PM_W{1'b0}}
                                                         : {2'b01, {(PM_W-2){1'b0}}};
   localparam logic [PM_W:0]   NORM_OFS = {2'b01, {(PM_W-1){1'b0}}};

   logic [PM_W-1:0] pmQ, pmD;
   logic            decQ, decD;
   logic            validQ, validD;

   logic [PM_W:0]   sumA, sumB;
   logic [PM_W:0]   selVal;
   logic            pickB;
   logic [PM_W:0]   normVal;
   logic [PM_W-1:0] newPm;

   always_comb begin
      sumA   = {1'b0, pm_a} + {{(PM_W+1-BM_W){1'b0}}, bm_a};
      sumB   = {1'b0, pm_b} + {{(PM_W+1-BM_W){1'b0}}, bm_b};
      pickB  = (sumB < sumA);
      selVal = pickB ? sumB : sumA;
      normVal = norm_in ? (selVal - NORM_OFS) : selVal;
   end

`ifdef ACS_SAT_EN
   always_comb begin
      newPm = normVal[PM_W] ? {PM_W{1'b1}} : normVal[PM_W-1:0];
   end
`else
   // The carry bit is simply dropped, so the metric wraps.
   logic unusedNormTop;
   assign unusedNormTop = normVal[PM_W];

   always_comb begin
      newPm = normVal[PM_W-1:0];
   end
`endif

   always_comb begin
      pmD    = pmQ;
      decD   = decQ;
      validD = 1'b0;
      if (start) begin
         pmD  = START_PM;
         decD = 1'b0;
      end else if (in_valid) begin
         pmD    = newPm;
         decD   = pickB;
         validD = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pmQ    <= START_PM;
         decQ   <= 1'b0;
         validQ <= 1'b0;
      end else begin
         pmQ    <= pmD;
         decQ   <= decD;
         validQ <= validD;
      end
   end

   assign pm_out    = pmQ;
   assign decision  = decQ;
   assign out_valid = validQ;
   assign pm_msb    = pmQ[PM_W-1];

endmodule

// File: tb/tb_acs_node.sv
// Directed self-checking bench for acs_node: one node with IS_ZERO=0 and a shadow node with IS_ZERO=1.
// Expected values are hand-computed for PM_W=8, BM_W=2.
module tb_acs_node;

   logic       clk;
   logic       rst;
   logic       start;
   logic       inValid;
   logic [7:0] pmA, pmB;
   logic [1:0] bmA, bmB;
   logic       normIn;

   logic [7:0] pmOut, pmOut0;
   logic       decision, decision0;
   logic       outValid, outValid0;
   logic       pmMsb, pmMsb0;

   int checks = 0;
   int errors = 0;

   acs_node #(.PM_W(8), .BM_W(2), .IS_ZERO(0)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(inValid),
      .pm_a(pmA), .pm_b(pmB), .bm_a(bmA), .bm_b(bmB), .norm_in(normIn),
      .pm_out(pmOut), .decision(decision), .out_valid(outValid), .pm_msb(pmMsb)
   );

   acs_node #(.PM_W(8), .BM_W(2), .IS_ZERO(1)) dut0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(inValid),
      .pm_a(pmA), .pm_b(pmB), .bm_a(bmA), .bm_b(bmB), .norm_in(normIn),
      .pm_out(pmOut0), .decision(decision0), .out_valid(outValid0), .pm_msb(pmMsb0)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one step's inputs, clock it in and settle just past the edge.
   task automatic applyStimulus(input logic st, input logic iv,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] ba, input logic [1:0] bb,
                                input logic nrm);
      start   = st;
      inValid = iv;
      pmA     = a;
      pmB     = b;
      bmA     = ba;
      bmB     = bb;
      normIn  = nrm;
      @(posedge clk);
      #1;
   endtask

   // One comparison with its own immediate assertion.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; inValid = 1'b0; normIn = 1'b0;
      pmA = '0; pmB = '0; bmA = '0; bmB = '0;

      #12;
      checkOutput("rst_pm",     32'(pmOut),    32'd64);
      checkOutput("rst_dec",    32'(decision), 32'd0);
      checkOutput("rst_valid",  32'(outValid), 32'd0);
      checkOutput("rst_msb",    32'(pmMsb),    32'd0);
      checkOutput("rst_pm_s0",  32'(pmOut0),   32'd0);

      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 2'd0, 2'd0, 1'b0);
      checkOutput("start_pm",    32'(pmOut),    32'd64);
      checkOutput("start_valid", 32'(outValid), 32'd0);
      checkOutput("start_pm_s0", 32'(pmOut0),   32'd0);

      // 12 vs 10: branch 1 wins.
      applyStimulus(1'b0, 1'b1, 8'd10, 8'd9, 2'd2, 2'd1, 1'b0);
      checkOutput("t2_pm",    32'(pmOut),    32'd10);
      checkOutput("t2_dec",   32'(decision), 32'd1);
      checkOutput("t2_valid", 32'(outValid), 32'd1);
      checkOutput("t2_pm_s0", 32'(pmOut0),   32'd10);

      applyStimulus(1'b0, 1'b0, 8'd1, 8'd1, 2'd0, 2'd0, 1'b1);
      checkOutput("hold_pm",    32'(pmOut),    32'd10);
      checkOutput("hold_dec",   32'(decision), 32'd1);
      checkOutput("hold_valid", 32'(outValid), 32'd0);

      // Tie at 6 keeps branch 0.
      applyStimulus(1'b0, 1'b1, 8'd5, 8'd4, 2'd1, 2'd2, 1'b0);
      checkOutput("tie_pm",  32'(pmOut),    32'd6);
      checkOutput("tie_dec", 32'(decision), 32'd0);

      // 200 selected, normalised to 72.
      applyStimulus(1'b0, 1'b1, 8'd200, 8'd210, 2'd0, 2'd0, 1'b1);
      checkOutput("norm_pm",  32'(pmOut),    32'd72);
      checkOutput("norm_dec", 32'(decision), 32'd0);
      checkOutput("norm_msb", 32'(pmMsb),    32'd0);

      // 151 vs 143: branch 1, MSB set.
      applyStimulus(1'b0, 1'b1, 8'd150, 8'd140, 2'd1, 2'd3, 1'b0);
      checkOutput("msb_pm",  32'(pmOut),    32'd143);
      checkOutput("msb_dec", 32'(decision), 32'd1);
      checkOutput("msb_msb", 32'(pmMsb),    32'd1);

      // 253 vs 242, normalised: 114.
      applyStimulus(1'b0, 1'b1, 8'd250, 8'd240, 2'd3, 2'd2, 1'b1);
      checkOutput("normb_pm",  32'(pmOut),    32'd114);
      checkOutput("normb_dec", 32'(decision), 32'd1);

      // Tie at 257: clamp or wrap.
      applyStimulus(1'b0, 1'b1, 8'd255, 8'd255, 2'd2, 2'd2, 1'b0);
`ifdef ACS_SAT_EN
      checkOutput("ovf_pm", 32'(pmOut), 32'd255);
`else
      checkOutput("ovf_pm", 32'(pmOut), 32'd1);
`endif
      checkOutput("ovf_dec", 32'(decision), 32'd0);

      // 258 normalised to 130 fits without clamping.
      applyStimulus(1'b0, 1'b1, 8'd255, 8'd255, 2'd3, 2'd3, 1'b1);
      checkOutput("ovfn_pm", 32'(pmOut), 32'd130);

      // Start wins over in_valid.
      applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 2'd0, 2'd0, 1'b0);
      checkOutput("sv_pm",    32'(pmOut),    32'd64);
      checkOutput("sv_dec",   32'(decision), 32'd0);
      checkOutput("sv_valid", 32'(outValid), 32'd0);

      applyStimulus(1'b0, 1'b1, 8'd20, 8'd30, 2'd0, 2'd0, 1'b0);
      checkOutput("burst1_pm", 32'(pmOut), 32'd20);

      applyStimulus(1'b0, 1'b1, 8'd30, 8'd10, 2'd0, 2'd1, 1'b0);
      checkOutput("burst2_pm",    32'(pmOut),    32'd11);
      checkOutput("burst2_dec",   32'(decision), 32'd1);
      checkOutput("burst2_valid", 32'(outValid), 32'd1);

      // Asynchronous reset mid-burst, observed before the next edge.
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_pm",    32'(pmOut),    32'd64);
      checkOutput("arst_dec",   32'(decision), 32'd0);
      checkOutput("arst_valid", 32'(outValid), 32'd0);
      checkOutput("arst_pm_s0", 32'(pmOut0),   32'd0);

      @(negedge clk);
      rst = 1'b0;
      inValid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_valid", 32'(outValid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
